gx_reconfig_rmw_master: RTL and testbench
=========================================

Name: gx_reconfig_rmw_master

Overview:
- Avalon-MM initiator that drives the transceiver reconfiguration slave port of the 4-lane GX latency-optimised PHY (reconfig_write/read/address/writedata/readdata/waitrequest).
- Accepts byte-level commands from GBT-bank control logic, for example polarity, CDR or PMA tweaks. Each command is a read, a write or a read-modify-write.
- Waits for the target lane's calibration to finish, bounds every bus wait with a timeout, and returns one response per command.

Parameters:
- LANE_W, 2, lane-select width; reconfig_address = {lane, offset}.
- OFFSET_W, 10, per-lane register offset width; LANE_W+OFFSET_W = 12.
- NUM_LANES, 4, number of cal_busy inputs.
- TIMEOUT, 1023, maximum cycles spent in any wait state before abort; counter width is clog2(TIMEOUT+1).

Ports:
- reconfig_clk  in  1  sole clock.
- reconfig_reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_lane  in  LANE_W  target lane.
- cmd_offset  in  OFFSET_W  register offset.
- cmd_mask  in  8  bits of byte 0 to modify; 00 = read only, FF = write only, otherwise RMW.
- cmd_data  in  8  new bit values, used under cmd_mask.
- cal_busy  in  NUM_LANES  OR of the PHY rx_cal_busy and tx_cal_busy per lane.
- reconfig_write  out  1  Avalon write.
- reconfig_read  out  1  Avalon read.
- reconfig_address  out  12  Avalon address.
- reconfig_writedata  out  32  Avalon write data.
- reconfig_readdata  in  32  Avalon read data.
- reconfig_waitrequest  in  1  Avalon waitrequest.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_data  out  8  result byte.
- rsp_error  out  1  timeout abort, qualified by rsp_valid.

Behaviour:
- Reset values: all outputs 0, including cmd_ready. Counter 0, state IDLE. Reset asserted mid-transaction drops read/write immediately and emits no response.
- State IDLE: cmd_ready=1. On cmd_valid&cmd_ready (cycle T), register lane, offset, mask and data, then go to WAIT_CAL.
- State WAIT_CAL: cmd_ready=0.
  - If cal_busy[lane]=0: go to RD when mask!=FF, else go to WR.
  - Result: reconfig_read or reconfig_write first asserts at T+2 at the earliest.
- State RD: read=1, address={lane,offset}, held stable.
  - Transfer completes in the cycle where waitrequest=0; readdata is captured in that cycle.
  - If mask=00, go to DONE. Otherwise go to WR; read deasserts and write asserts the next cycle.
- State WR: write=1, address unchanged.
  - writedata = {rd[31:8], (rd[7:0]&~mask)|(data&mask)} for RMW.
  - writedata = {24'h0, data} for write-only (mask=FF).
  - Completes in the cycle where waitrequest=0, then go to DONE.
- State DONE: for one cycle, rsp_valid=1 with rsp_error=0. Then go to IDLE, so cmd_ready returns the cycle after rsp_valid.
  - rsp_data = rd[7:0] for read-only.
  - rsp_data = the written byte for RMW and write-only.
- Read and write are never asserted together. Address and writedata never change while waitrequest=1.
- Timeout:
  - Counter clears on entry to WAIT_CAL, RD and WR, and increments every cycle spent in them.
  - When it reaches TIMEOUT, read/write deassert the next cycle and the block enters DONE with rsp_error=1 and rsp_data=0.
  - A completion (waitrequest=0) in the same cycle the counter hits TIMEOUT counts as success.
- cal_busy for lanes other than the target lane is ignored. cal_busy rising during RD or WR is ignored.
- Throughput: one command in flight, no queueing. cmd_valid while cmd_ready=0 is held off.

Test Plan:
- Read-only, lane 2, offset 0x1A5, mask 00, readdata 0xDEADBE5A, waitrequest low 3 cycles after read -> address 0x9A5; one read of 4 cycles; rsp_data 0x5A, rsp_error 0; no write.
- RMW, lane 1, offset 0x00A, mask 0x0C, data 0x08, readdata 0x123456F3, zero-wait slave -> write at 0x40A with writedata 0x123456FB; rsp_data 0xFB; read→write back-to-back.
- Write-only, lane 3, mask FF, data 0x81, with cal_busy[3] high 50 cycles and cal_busy[0] high throughout -> no bus activity for 50 cycles; then writedata 0x00000081 at 0xC00+offset; rsp_error 0.
- Slave holds waitrequest high forever, TIMEOUT=1023 -> read drops after 1023 cycles; rsp_valid with rsp_error 1; next command accepted normally.
- reconfig_reset asserted mid-RD -> read, rsp_valid and cmd_ready are 0 asynchronously. After release: IDLE, cmd_ready 1, no stray response.
- Back-to-back commands with cmd_valid held high -> second accepted exactly one cycle after the first rsp_valid; Avalon protocol checker reports no violations.

Source files
------------

// File: rtl/gx_reconfig_rmw_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gx_reconfig_rmw_master                                       |
// | Description : Avalon-MM initiator issuing byte read / write / RMW commands |
// |               to the GX PHY reconfiguration port, with calibration gating  |
// |               and bounded bus waits.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gx_reconfig_rmw_master #(
    parameter int LANE_W    = 2,
    parameter int OFFSET_W  = 10,
    parameter int NUM_LANES = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic                       reconfig_clk,
    input  logic                       reconfig_reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [LANE_W-1:0]          cmd_lane,
    input  logic [OFFSET_W-1:0]        cmd_offset,
    input  logic [7:0]                 cmd_mask,
    input  logic [7:0]                 cmd_data,
    input  logic [NUM_LANES-1:0]       cal_busy,
    output logic                       reconfig_write,
    output logic                       reconfig_read,
    output logic [LANE_W+OFFSET_W-1:0] reconfig_address,
    output logic [31:0]                reconfig_writedata,
    input  logic [31:0]                reconfig_readdata,
    input  logic                       reconfig_waitrequest,
    output logic                       rsp_valid,
    output logic [7:0]                 rsp_data,
    output logic                       rsp_error
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    // The wait aborts on the edge where the counter would reach TIMEOUT.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_CAL = 3'd1,
        S_RD       = 3'd2,
        S_WR       = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [LANE_W-1:0]     r_lane;
    logic [OFFSET_W-1:0]   r_offset;
    logic [7:0]            r_mask;
    logic [7:0]            r_data;
    logic [7:0]            w_merged;
    logic                  w_expire;

    assign w_merged = (reconfig_readdata[7:0] & ~r_mask) | (r_data & r_mask);
    assign w_expire = (r_cnt == c_CNT_LAST);

    always_ff @(posedge reconfig_clk or posedge reconfig_reset) begin
        if (reconfig_reset) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_lane             <= '0;
            r_offset           <= '0;
            r_mask             <= '0;
            r_data             <= '0;
            cmd_ready          <= 1'b0;
            reconfig_write     <= 1'b0;
            reconfig_read      <= 1'b0;
            reconfig_address   <= '0;
            reconfig_writedata <= '0;
            rsp_valid          <= 1'b0;
            rsp_data           <= '0;
            rsp_error          <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_lane    <= cmd_lane;
                        r_offset  <= cmd_offset;
                        r_mask    <= cmd_mask;
                        r_data    <= cmd_data;
                        r_cnt     <= '0;
                        cmd_ready <= 1'b0;
                        r_state   <= S_WAIT_CAL;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_WAIT_CAL: begin
                    if (!cal_busy[r_lane]) begin
                        reconfig_address <= {r_lane, r_offset};
                        r_cnt            <= '0;
                        if (r_mask == 8'hFF) begin
                            reconfig_write     <= 1'b1;
                            reconfig_writedata <= {24'h0, r_data};
                            r_state            <= S_WR;
                        end else begin
                            reconfig_read <= 1'b1;
                            r_state       <= S_RD;
                        end
                    end else if (w_expire) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_data  <= 8'h00;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RD: begin
                    if (!reconfig_waitrequest) begin
                        reconfig_read <= 1'b0;
                        if (r_mask == 8'h00) begin
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b0;
                            rsp_data  <= reconfig_readdata[7:0];
                            r_state   <= S_DONE;
                        end else begin
                            reconfig_write     <= 1'b1;
                            reconfig_writedata <= {reconfig_readdata[31:8], w_merged};
                            r_cnt              <= '0;
                            r_state            <= S_WR;
                        end
                    end else if (w_expire) begin
                        reconfig_read <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_error     <= 1'b1;
                        rsp_data      <= 8'h00;
                        r_state       <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WR: begin
                    if (!reconfig_waitrequest) begin
                        reconfig_write <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_error      <= 1'b0;
                        rsp_data       <= reconfig_writedata[7:0];
                        r_state        <= S_DONE;
                    end else if (w_expire) begin
                        reconfig_write <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_error      <= 1'b1;
                        rsp_data       <= 8'h00;
                        r_state        <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    reconfig_read  <= 1'b0;
                    reconfig_write <= 1'b0;
                    cmd_ready      <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gx_reconfig_rmw_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_gx_reconfig_rmw_master                                    |
// | Description : Directed self-checking bench for gx_reconfig_rmw_master.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_gx_reconfig_rmw_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_lane = '0;
    logic [9:0]  cmd_offset = '0;
    logic [7:0]  cmd_mask = '0;
    logic [7:0]  cmd_data = '0;
    logic [3:0]  cal_busy = '0;
    logic        wr;
    logic        rd;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        waitreq;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_error;

    always #5 clk = ~clk;

    gx_reconfig_rmw_master dut (
        .reconfig_clk         (clk),
        .reconfig_reset       (rst),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_lane             (cmd_lane),
        .cmd_offset           (cmd_offset),
        .cmd_mask             (cmd_mask),
        .cmd_data             (cmd_data),
        .cal_busy             (cal_busy),
        .reconfig_write       (wr),
        .reconfig_read        (rd),
        .reconfig_address     (addr),
        .reconfig_writedata   (wdata),
        .reconfig_readdata    (rdata),
        .reconfig_waitrequest (waitreq),
        .rsp_valid            (rsp_valid),
        .rsp_data             (rsp_data),
        .rsp_error            (rsp_error)
    );

    // Slave model: waitrequest held for wait_lat cycles of each request, or forever when hung.
    int          wait_lat = 0;
    bit          hang = 1'b0;
    int          held = 0;
    logic [31:0] rdata_val = '0;
    assign waitreq = (rd || wr) && (hang || (held < wait_lat));
    assign rdata   = rdata_val;

    int          cyc = 0;
    int          n_rd = 0, n_wr = 0, n_rsp = 0, n_acc = 0, rd_hi = 0, wr_hi = 0, viol = 0;
    int          rd_done_cyc = 0, rd_start_cyc = 0, wr_start_cyc = 0, rsp_cyc = 0, acc_cyc = 0;
    logic [11:0] rd_addr = '0, wr_addr = '0, p_addr = '0;
    logic [31:0] wr_data = '0, p_wd = '0;
    logic [7:0]  rsp_d = '0;
    logic        rsp_e = 1'b0, p_read = 1'b0, p_busy = 1'b0;
    logic        p_write = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        p_read  <= rd;
        p_write <= wr;
        p_addr  <= addr;
        p_wd    <= wdata;
        p_busy  <= !rst && (rd || wr) && waitreq;
        if (rst) begin
            held <= 0;
        end else begin
            held <= ((rd || wr) && waitreq) ? held + 1 : 0;
            if (rd) rd_hi <= rd_hi + 1;
            if (wr) wr_hi <= wr_hi + 1;
            if (rd && !p_read) rd_start_cyc <= cyc;
            if (wr && !p_write) wr_start_cyc <= cyc;
            if (rd && !waitreq) begin
                n_rd        <= n_rd + 1;
                rd_addr     <= addr;
                rd_done_cyc <= cyc;
            end
            if (wr && !waitreq) begin
                n_wr    <= n_wr + 1;
                wr_addr <= addr;
                wr_data <= wdata;
            end
            if (rsp_valid) begin
                n_rsp   <= n_rsp + 1;
                rsp_d   <= rsp_data;
                rsp_e   <= rsp_error;
                rsp_cyc <= cyc;
            end
            if (cmd_valid && cmd_ready) begin
                n_acc   <= n_acc + 1;
                acc_cyc <= cyc;
            end
            if (rd && wr) viol <= viol + 1;
            else if (p_busy && ((addr != p_addr) || (wdata != p_wd))) viol <= viol + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_acc(input string tag, input int target, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #1;
            if (n_acc >= target) got = 1'b1;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s accept timeout observed none expected acceptance", tag);
        end
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int  base;
        bit  got;
        base = n_rsp;
        got  = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #1;
            if (n_rsp != base) got = 1'b1;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s response timeout observed none expected rsp_valid", tag);
        end
    endtask

    task automatic send_cmd(input string tag, input logic [1:0] lane, input logic [9:0] off,
                            input logic [7:0] mask, input logic [7:0] data);
        int base;
        base       = n_acc;
        cmd_lane   = lane;
        cmd_offset = off;
        cmd_mask   = mask;
        cmd_data   = data;
        cmd_valid  = 1'b1;
        wait_acc(tag, base + 1, 20);
        cmd_valid  = 1'b0;
    endtask

    int b_rd, b_wr, b_rhi, b_whi, b_rsp, b_acc, r1_cyc;
    logic [7:0] r1_d;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_read",      32'(rd),        32'd0);
        check("rst_write",     32'(wr),        32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Read-only, lane 2, three wait cycles
        wait_lat = 3; rdata_val = 32'hDEADBE5A;
        b_rd = n_rd; b_wr = n_wr; b_rhi = rd_hi;
        send_cmd("t1", 2'd2, 10'h1A5, 8'h00, 8'h00);
        wait_rsp("t1", 40);
        check("t1_latency",  32'(rd_start_cyc - acc_cyc), 32'd2);
        check("t1_addr",     32'(rd_addr),         32'h9A5);
        check("t1_reads",    32'(n_rd - b_rd),     32'd1);
        check("t1_rd_cyc",   32'(rd_hi - b_rhi),   32'd4);
        check("t1_writes",   32'(n_wr - b_wr),     32'd0);
        check("t1_rsp_data", 32'(rsp_d),           32'h5A);
        check("t1_rsp_err",  32'(rsp_e),           32'd0);

        // RMW, lane 1, zero-wait slave
        wait_lat = 0; rdata_val = 32'h123456F3;
        b_wr = n_wr;
        send_cmd("t2", 2'd1, 10'h00A, 8'h0C, 8'h08);
        wait_rsp("t2", 40);
        check("t2_wr_addr",  32'(wr_addr),         32'h40A);
        check("t2_wr_data",  wr_data,              32'h123456FB);
        check("t2_b2b",      32'(wr_start_cyc - rd_done_cyc), 32'd1);
        check("t2_writes",   32'(n_wr - b_wr),     32'd1);
        check("t2_rsp_data", 32'(rsp_d),           32'hFB);

        // Write-only, lane 3 calibrating, lane 0 busy throughout
        cal_busy = 4'b1001;
        b_wr = n_wr; b_rhi = rd_hi; b_whi = wr_hi;
        send_cmd("t3", 2'd3, 10'h055, 8'hFF, 8'h81);
        repeat (50) @(posedge clk);
        #1;
        check("t3_bus_idle", 32'((rd_hi - b_rhi) + (wr_hi - b_whi)), 32'd0);
        cal_busy = 4'b0001;
        wait_rsp("t3", 40);
        check("t3_wr_addr",  32'(wr_addr),         32'hC55);
        check("t3_wr_data",  wr_data,              32'h00000081);
        check("t3_writes",   32'(n_wr - b_wr),     32'd1);
        check("t3_rsp_err",  32'(rsp_e),           32'd0);
        check("t3_rsp_data", 32'(rsp_d),           32'h81);
        cal_busy = 4'b0000;

        // Hung slave: read aborts after TIMEOUT cycles
        hang = 1'b1;
        b_rd = n_rd; b_rhi = rd_hi;
        send_cmd("t4", 2'd0, 10'h3FF, 8'h00, 8'h00);
        wait_rsp("t4", 1100);
        check("t4_rd_cyc",   32'(rd_hi - b_rhi),   32'd1023);
        check("t4_reads",    32'(n_rd - b_rd),     32'd0);
        check("t4_rsp_err",  32'(rsp_e),           32'd1);
        check("t4_rsp_data", 32'(rsp_d),           32'h00);
        hang = 1'b0; wait_lat = 1; rdata_val = 32'h000000A5;
        send_cmd("t4b", 2'd0, 10'h010, 8'h00, 8'h00);
        wait_rsp("t4b", 40);
        check("t4b_rsp_data", 32'(rsp_d),          32'hA5);
        check("t4b_rsp_err",  32'(rsp_e),          32'd0);

        // Reset mid-read
        hang = 1'b1;
        send_cmd("t5", 2'd2, 10'h020, 8'h00, 8'h00);
        for (int i = 0; i < 10 && !rd; i++) begin
            @(posedge clk); #1;
        end
        check("t5_read_up", 32'(rd), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_read",  32'(rd),        32'd0);
        check("t5_rst_rdy",   32'(cmd_ready), 32'd0);
        check("t5_rst_rsp",   32'(rsp_valid), 32'd0);
        hang = 1'b0; wait_lat = 0;
        b_rsp = n_rsp;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t5_rel_rdy",   32'(cmd_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_rsp",    32'(n_rsp - b_rsp), 32'd0);

        // Back-to-back commands with cmd_valid held high
        rdata_val = 32'h000000C3;
        b_acc = n_acc;
        cmd_lane = 2'd2; cmd_offset = 10'h001; cmd_mask = 8'h00; cmd_data = 8'h00;
        cmd_valid = 1'b1;
        wait_acc("t6a", b_acc + 1, 20);
        cmd_lane = 2'd1; cmd_offset = 10'h002; cmd_mask = 8'hFF; cmd_data = 8'h3C;
        wait_rsp("t6a", 40);
        r1_cyc = rsp_cyc;
        r1_d   = rsp_d;
        wait_acc("t6b", b_acc + 2, 20);
        cmd_valid = 1'b0;
        check("t6_accept_gap", 32'(acc_cyc - r1_cyc), 32'd1);
        wait_rsp("t6b", 40);
        check("t6_rsp1_data",  32'(r1_d),    32'hC3);
        check("t6_rsp2_data",  32'(rsp_d),   32'h3C);
        check("t6_wr_addr",    32'(wr_addr), 32'h402);
        check("t6_wr_data",    wr_data,      32'h0000003C);
        check("protocol_viol", 32'(viol),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
